// File: rtl/fir_pkg.sv
// Shared constants, state encoding and address helper for the 11-tap FIR engine.
package fir_pkg;

    localparam int NUM_TAPS = 11;
    localparam int DW       = 32;
    localparam int AW       = 12;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] DRAIN_IDX = IDX_W'(NUM_TAPS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        WAIT_IN = 3'd2,
        MAC     = 3'd3,
        OUT     = 3'd4,
        DONE    = 3'd5
    } state_e;

    // BRAMs are byte addressed; each word sits at index*4.
    function automatic logic [AW-1:0] word_to_byte(input logic [IDX_W-1:0] idx);
        return {{(AW-IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/fir_mod_idx.sv
// Modulo-MOD index register with load, increment and decrement, wrapping at both ends.
module fir_mod_idx
    import fir_pkg::*;
#(
    parameter int MOD = NUM_TAPS,
    parameter int W   = IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] idx
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (load) begin
            idx <= load_val;
        end else if (inc) begin
            idx <= (idx == W'(MOD - 1)) ? '0 : idx + W'(1);
        end else if (dec) begin
            idx <= (idx == '0) ? W'(MOD - 1) : idx - W'(1);
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// FIR sequencer: clears the circular data buffer, stores each input sample,
// runs 11 tap*data MACs against the BRAMs and streams the accumulated result.
module fir_mac_engine
    import fir_pkg::*;
(
    input  logic          axis_clk,
    input  logic          axis_rst_n,
    input  logic          ap_start,
    input  logic [31:0]   data_length,
    output logic          ap_idle,
    output logic          ap_done,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    input  logic          ss_tlast,
    output logic          ss_tready,
    input  logic          sm_tready,
    output logic          sm_tvalid,
    output logic [DW-1:0] sm_tdata,
    output logic          sm_tlast,
    output logic          tap_EN,
    output logic [3:0]    tap_WE,
    output logic [AW-1:0] tap_A,
    input  logic [DW-1:0] tap_Do,
    output logic          data_EN,
    output logic [3:0]    data_WE,
    output logic [AW-1:0] data_A,
    output logic [DW-1:0] data_Di,
    input  logic [DW-1:0] data_Do
);

    state_e           state;
    logic [IDX_W-1:0] cyc;
    logic [31:0]      cnt;
    logic [31:0]      len_q;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    prod;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] rd_idx;

    logic start_ok;
    logic in_hs;
    logic out_hs;
    logic last;
    logic mac_issue;
    logic unused_tlast;

    assign unused_tlast = ss_tlast;

    assign start_ok  = ap_start && (state == IDLE || state == DONE);
    assign in_hs     = (state == WAIT_IN) && ss_tvalid;
    assign out_hs    = (state == OUT) && sm_tready;
    assign last      = (cnt == len_q);
    assign mac_issue = (state == MAC) && (cyc <= LAST_IDX);
    assign prod      = tap_Do * data_Do;

    fir_mod_idx u_ptr (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .load     (start_ok),
        .load_val ('0),
        .inc      (out_hs && !last),
        .dec      (1'b0),
        .idx      (ptr)
    );

    // Walks backwards through history: (ptr - k) mod NUM_TAPS for issue cycle k.
    fir_mod_idx u_rd (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .load     (in_hs),
        .load_val (ptr),
        .inc      (1'b0),
        .dec      (mac_issue),
        .idx      (rd_idx)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state <= IDLE;
            cyc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ap_start) begin
                        state <= CLEAR;
                        cyc   <= '0;
                        cnt   <= '0;
                        len_q <= data_length;
                    end
                end
                CLEAR: begin
                    if (cyc == LAST_IDX) begin
                        cyc   <= '0;
                        state <= (len_q == 32'd0) ? DONE : WAIT_IN;
                    end else begin
                        cyc <= cyc + IDX_W'(1);
                    end
                end
                WAIT_IN: begin
                    if (ss_tvalid) begin
                        cnt   <= cnt + 32'd1;
                        acc   <= '0;
                        cyc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    // Read data trails the issued address by one cycle.
                    if (cyc != '0) begin
                        acc <= acc + prod;
                    end
                    if (cyc == DRAIN_IDX) begin
                        state <= OUT;
                    end else begin
                        cyc <= cyc + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (sm_tready) begin
                        state <= last ? DONE : WAIT_IN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tap_EN  = 1'b0;
        tap_A   = '0;
        data_EN = 1'b0;
        data_WE = 4'h0;
        data_A  = '0;
        data_Di = '0;
        case (state)
            CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_to_byte(cyc);
            end
            WAIT_IN: begin
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = word_to_byte(ptr);
                    data_Di = ss_tdata;
                end
            end
            MAC: begin
                if (mac_issue) begin
                    tap_EN  = 1'b1;
                    data_EN = 1'b1;
                    tap_A   = word_to_byte(cyc);
                    data_A  = word_to_byte(rd_idx);
                end
            end
            default: ;
        endcase
    end

    assign tap_WE    = 4'h0;
    assign ap_idle   = (state == IDLE) || (state == DONE);
    assign ap_done   = (state == DONE);
    assign ss_tready = (state == WAIT_IN);
    assign sm_tvalid = (state == OUT);
    assign sm_tdata  = acc;
    assign sm_tlast  = (state == OUT) && last;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with behavioural tap/data BRAMs and a
// direct-form FIR reference model over the samples of the current run.
module tb_fir_mac_engine;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        ap_start;
    logic [31:0] data_length;
    logic        ap_idle;
    logic        ap_done;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;
    logic        sm_tready;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        tap_EN;
    logic [3:0]  tap_WE;
    logic [11:0] tap_A;
    logic [31:0] tap_Do;
    logic        data_EN;
    logic [3:0]  data_WE;
    logic [11:0] data_A;
    logic [31:0] data_Di;
    logic [31:0] data_Do;

    logic [31:0] tap_mem  [0:15];
    logic [31:0] data_mem [0:15];
    logic        fill_req;
    int          wr_cnt  = 0;
    int          out_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] hist[$];
    int          run_len;
    int          wr_base;
    int          out_base;

    always #5 axis_clk = ~axis_clk;

    fir_mac_engine dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .sm_tready   (sm_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .tap_EN      (tap_EN),
        .tap_WE      (tap_WE),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .data_EN     (data_EN),
        .data_WE     (data_WE),
        .data_A      (data_A),
        .data_Di     (data_Di),
        .data_Do     (data_Do)
    );

    // Single-port BRAM with registered read; fill_req stamps stale contents.
    always @(posedge axis_clk) begin
        if (fill_req) begin
            for (int i = 0; i < 16; i++) data_mem[i] <= 32'h0000DEAD;
        end else if (data_EN) begin
            if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
            data_Do <= data_mem[data_A[5:2]];
        end
    end

    always @(posedge axis_clk) begin
        if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
    end

    always @(posedge axis_clk) begin
        if (data_EN && data_WE != 4'h0) wr_cnt <= wr_cnt + 1;
        if (sm_tvalid && sm_tready) out_cnt <= out_cnt + 1;
    end

    function automatic logic [31:0] modelY();
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 11; k++) begin
            if (k < hist.size()) s += tap_mem[k] * hist[hist.size() - 1 - k];
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setTaps(input int ramp);
        for (int k = 0; k < 16; k++) tap_mem[k] = (ramp != 0) ? 32'(k + 1) : 32'd1;
    endtask

    task automatic startRun(input int len);
        @(negedge axis_clk);
        ap_start    = 1'b1;
        data_length = 32'(len);
        @(posedge axis_clk);
        #1 ap_start = 1'b0;
        hist.delete();
        run_len  = len;
        wr_base  = wr_cnt;
        out_base = out_cnt;
    endtask

    task automatic applyStimulus(input logic [31:0] x);
        int n;
        n = 0;
        @(negedge axis_clk);
        ss_tvalid = 1'b1;
        ss_tdata  = x;
        while (!ss_tready && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        if (!ss_tready) begin
            checkOutput("in_timeout", 32'd0, 32'd1);
            ss_tvalid = 1'b0;
        end else begin
            @(posedge axis_clk);
            #1 ss_tvalid = 1'b0;
            hist.push_back(x);
        end
    endtask

    task automatic collectOutput(input string tag, input int hold);
        logic [31:0] exp_y;
        logic        exp_last;
        int          n;
        exp_y    = modelY();
        exp_last = (hist.size() == run_len);
        n = 0;
        if (hold > 0) sm_tready = 1'b0;
        @(negedge axis_clk);
        while (!sm_tvalid && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        if (!sm_tvalid) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            sm_tready = 1'b1;
        end else begin
            checkOutput({tag, "_y"}, sm_tdata, exp_y);
            checkOutput({tag, "_last"}, 32'(sm_tlast), 32'(exp_last));
            for (int c = 0; c < hold; c++) begin
                @(negedge axis_clk);
                checkOutput({tag, "_hold_valid"}, 32'(sm_tvalid), 32'd1);
                checkOutput({tag, "_hold_y"}, sm_tdata, exp_y);
                checkOutput({tag, "_hold_ssrdy"}, 32'(ss_tready), 32'd0);
            end
            if (hold > 0) checkOutput({tag, "_hold_writes"}, 32'(wr_cnt - wr_base), 32'(11 + hist.size()));
            sm_tready = 1'b1;
            @(posedge axis_clk);
            #1;
        end
    endtask

    initial begin
        int          n;
        logic        rdy_seen;
        axis_rst_n  = 1'b0;
        ap_start    = 1'b0;
        data_length = 32'd0;
        ss_tvalid   = 1'b0;
        ss_tdata    = 32'd0;
        ss_tlast    = 1'b0;
        sm_tready   = 1'b1;
        fill_req    = 1'b1;
        setTaps(1);
        repeat (3) @(negedge axis_clk);
        fill_req   = 1'b0;
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        checkOutput("rst_idle", 32'(ap_idle), 32'd1);
        checkOutput("rst_done", 32'(ap_done), 32'd0);
        checkOutput("rst_ssrdy", 32'(ss_tready), 32'd0);
        checkOutput("rst_smvalid", 32'(sm_tvalid), 32'd0);
        checkOutput("rst_data_en", 32'(data_EN), 32'd0);

        // Stale 0xDEAD history must be cleared: taps 1..11, inputs 5,0,0 -> 5,10,15.
        $display("[TB] clear test");
        startRun(3);
        checkOutput("clear_busy", 32'(ap_idle), 32'd0);
        applyStimulus(32'd5);
        n = 0;
        while (!sm_tvalid && n < 50) begin
            @(posedge axis_clk);
            #1 n++;
        end
        // 12 MAC cycles follow the handshake edge before OUT.
        checkOutput("latency", 32'(n), 32'd12);
        checkOutput("tap_we", 32'(tap_WE), 32'd0);
        collectOutput("clear0", 0);
        applyStimulus(32'd0);
        collectOutput("clear1", 0);
        applyStimulus(32'd0);
        collectOutput("clear2", 0);
        checkOutput("clear_done", 32'(ap_done), 32'd1);
        checkOutput("clear_idle", 32'(ap_idle), 32'd1);

        // Impulse through taps 1..11 reproduces the taps: 1,2,...,11.
        $display("[TB] impulse test");
        startRun(11);
        for (int i = 0; i < 11; i++) begin
            applyStimulus((i == 0) ? 32'd1 : 32'd0);
            collectOutput($sformatf("imp%0d", i), 0);
        end
        checkOutput("imp_done", 32'(ap_done), 32'd1);

        // Unit taps, inputs 1..15: 1,3,...,66 then 77,88,99,110 once the buffer wraps.
        $display("[TB] wrap test");
        @(negedge axis_clk);
        setTaps(0);
        startRun(15);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(32'(i + 1));
            collectOutput($sformatf("wrap%0d", i), (i == 12) ? 5 : 0);
        end
        checkOutput("wrap_outs", 32'(out_cnt - out_base), 32'd15);

        // Reset during MAC cycle 6 abandons the run.
        $display("[TB] reset test");
        @(negedge axis_clk);
        setTaps(1);
        startRun(5);
        applyStimulus(32'd7);
        repeat (6) @(negedge axis_clk);
        axis_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_idle", 32'(ap_idle), 32'd1);
        checkOutput("mid_rst_smvalid", 32'(sm_tvalid), 32'd0);
        checkOutput("mid_rst_ssrdy", 32'(ss_tready), 32'd0);
        checkOutput("mid_rst_tap_en", 32'(tap_EN), 32'd0);
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        startRun(1);
        applyStimulus(32'd2);
        collectOutput("post_rst", 0);
        checkOutput("post_rst_done", 32'(ap_done), 32'd1);

        // Zero-length run: straight to DONE after the 11 clear cycles.
        $display("[TB] zero-length test");
        startRun(0);
        n = 0;
        rdy_seen = 1'b0;
        while (!ap_done && n < 50) begin
            @(posedge axis_clk);
            #1 n++;
            if (ss_tready) rdy_seen = 1'b1;
        end
        checkOutput("len0_cycles", 32'(n), 32'd11);
        checkOutput("len0_ssrdy", 32'(rdy_seen), 32'd0);
        checkOutput("len0_outs", 32'(out_cnt - out_base), 32'd0);
        checkOutput("len0_writes", 32'(wr_cnt - wr_base), 32'd11);

        // ap_start during MAC is ignored: inputs 3,4 -> 3, 10.
        $display("[TB] start-during-mac test");
        startRun(2);
        applyStimulus(32'd3);
        repeat (3) @(negedge axis_clk);
        ap_start    = 1'b1;
        data_length = 32'd9;
        @(negedge axis_clk);
        ap_start = 1'b0;
        collectOutput("ign0", 0);
        applyStimulus(32'd4);
        collectOutput("ign1", 0);
        checkOutput("ign_outs", 32'(out_cnt - out_base), 32'd2);
        checkOutput("ign_done", 32'(ap_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
